// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters,
// with a one-entry registered response buffer.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [3:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_negative,
    output logic        rsp_zero,
    output logic        rsp_illegal
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [31:0] res_q, res_d;
    logic        neg_q, neg_d;
    logic        zero_q, zero_d;
    logic        ill_q, ill_d;

    logic        can_accept;
    logic        gnt0, gnt1;
    logic        acc;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [31:0] alu_res;
    logic        alu_ill;

    // Tie goes to the port that did not win the last accepted op.
    always_comb begin
        can_accept = !reset && (state_q == IDLE || rsp_ready);
        gnt0       = req0_valid && (!req1_valid || last_q);
        gnt1       = req1_valid && (!req0_valid || !last_q);
        req0_ready = can_accept && gnt0;
        req1_ready = can_accept && gnt1;
        acc        = req0_ready || req1_ready;
    end

    assign a  = gnt1 ? req1_in1 : req0_in1;
    assign b  = gnt1 ? req1_in2 : req0_in2;
    assign op = gnt1 ? req1_op  : req0_op;

    always_comb begin
        alu_res = 32'd0;
        alu_ill = 1'b0;
        case (op)
            4'b0000: alu_res = a + b;
            4'b0001: alu_res = a - b;
            4'b0010: alu_res = a << b[4:0];
            4'b0011: alu_res = {31'd0, $signed(a) < $signed(b)};
            4'b0100: alu_res = {31'd0, a < b};
            4'b0101: alu_res = a ^ b;
            4'b0110: alu_res = a >> b[4:0];
            4'b0111: alu_res = $unsigned($signed(a) >>> b[4:0]);
            4'b1000: alu_res = a | b;
            4'b1001: alu_res = a & b;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        res_d   = res_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        if (acc) begin
            state_d = RESP;
            last_d  = gnt1;
            id_d    = gnt1;
            res_d   = alu_res;
            neg_d   = alu_res[31];
            zero_d  = (alu_res == 32'd0);
            ill_d   = alu_ill;
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            res_q   <= 32'd0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = id_q;
    assign rsp_result   = res_q;
    assign rsp_negative = neg_q;
    assign rsp_zero     = zero_q;
    assign rsp_illegal  = ill_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit `alu` instance between two requesters: port 0 is the execute stage and port 1 is the address-generation/debug path. Each requester uses a valid/ready handshake. The block arbitrates round-robin and drives the winner's operands into the ALU. It registers the result, flags and requester ID into a one-entry response buffer with its own valid/ready handshake. An accepted operation always produces exactly one response.

## Interface
Parameters:
- (none): datapath fixed at 32 bits, two requesters, ALU op width 4.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request present
- req0_ready  out  1  port 0 request accepted this cycle
- req0_in1  in  32  port 0 operand 1
- req0_in2  in  32  port 0 operand 2
- req0_op  in  4  port 0 ALU op
- req1_valid / req1_ready / req1_in1 / req1_in2 / req1_op: same as port 0, for port 1
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_id  out  1  requester that issued the op (0/1)
- rsp_result  out  32  registered ALU result
- rsp_negative  out  1  registered ALU negative flag
- rsp_zero  out  1  registered ALU zero flag
- rsp_illegal  out  1  op was not a defined encoding

## Operation
- Op encodings:
  - add 0000
  - sub 0001
  - sll 0010
  - slt 0011
  - sltu 0100
  - xor 0101
  - srl 0110
  - sra 0111
  - or 1000
  - and 1001
  - 1010–1111 are illegal.
- State machine:
  - IDLE: response buffer empty.
  - RESP: buffer full, `rsp_valid`=1.
- `can_accept` = (state==IDLE) || rsp_ready.
- Arbitration is evaluated every cycle from the current valids and `last_grant`:
  - Only one valid: that port wins.
  - Both valid: the port ≠ `last_grant` wins.
  - Neither valid: no grant.
- `reqN_ready` = can_accept && grant==N. It is combinational from the valids. At most one ready is high per cycle. A ready is never high without its valid.
- On accept (valid && ready) the block does the following:
  - Muxes the winner's in1/in2/op into `alu`.
  - Latches result/negative/zero into the `rsp_*` registers and the winner into `rsp_id` and `last_grant`.
  - Enters or stays in RESP.
- Illegal op on accept: `rsp_result`=0, `rsp_negative`=0, `rsp_zero`=1, `rsp_illegal`=1. The op is still accepted and still consumes the grant.
- RESP with rsp_ready=1 and no accept: go to IDLE.
- RESP with rsp_ready=1 and an accept in the same cycle: stay in RESP with the new contents (back-to-back, no bubble).
- RESP with rsp_ready=0: all `rsp_*` outputs are held stable and both readys stay low.
- Flags are taken from the ALU as-is. slt/sltu produce 0/1, and `rsp_zero` reflects that value.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_negative`=0, `rsp_zero`=0, `rsp_illegal`=0, `last_grant`=1 (port 0 wins the first tie).
- `req*_ready` is 0 during any cycle in which reset is high.
- Latency: a request accepted at edge N gives `rsp_valid`=1 from edge N through the edge where rsp_ready is sampled high.
- Throughput: one op per cycle while rsp_ready stays high.
- Reset mid-operation: a pending response is discarded (`rsp_valid`=0 after the reset edge). A request presented during the reset cycle is not accepted.
- Simultaneous valids with a held response: no grant, and `last_grant` does not change until an accept actually occurs.
- A requester must hold valid and its operands stable until ready. Dropping valid early loses the request with no response.

## Test plan
- Single request, port 0: reset, then req0 add 0x0000000F+0x000000F0, rsp_ready=1 → req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=0x000000FF, negative=0, zero=1'b0, illegal=0.
- Tie after reset: both valid in the same cycle (port 0 sub 0−1, port 1 sltu 0xFF<0xFFFFFFFF), rsp_ready=1 → port 0 granted first, giving 0xFFFFFFFF with negative=1. The next cycle port 1 is granted, giving rsp_id=1 and result=1.
- Fairness: both valid continuously for 6 accepts → rsp_id sequence 0,1,0,1,0,1 with no idle cycle between responses.
- Backpressure: port 1 sra 0xFFFFFFFF>>>1 accepted, then rsp_ready=0 for 3 cycles with req0 valid → rsp_result=0xFFFFFFFF held, rsp_id=1, req0_ready=0 throughout. When rsp_ready rises, port 0 is accepted in that cycle.
- Illegal op: req0_op=4'b1010 → accepted; response illegal=1, result=0, zero=1, negative=0.
- Reset mid-op: assert reset while in RESP with rsp_ready=0 → next cycle rsp_valid=0, both readys 0. After release, a tie grants port 0.
